// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding, vector
// count/index width and the mismatch-locator helper used by the optional
// compare feature (TT_SWEEP_COMPARE_EN).
package tt_sweep_pkg;

    localparam int unsigned NUM_VECTORS = 16;
    localparam int unsigned IDX_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_e;

    // Lowest bit position where the two tables differ; 0 when they match.
    function automatic logic [IDX_W-1:0] first_diff(
        input logic [NUM_VECTORS-1:0] a,
        input logic [NUM_VECTORS-1:0] b
    );
        logic found;
        first_diff = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < NUM_VECTORS; i++) begin
            if (!found && (a[i] != b[i])) begin
                first_diff = IDX_W'(i);
                found      = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/truth_table_sweeper_settle.sv
// settle_counter: counts cycles while enabled and flags the last settle
// cycle (count == SETTLE_CYCLES-1). Width is derived from SETTLE_CYCLES.
module settle_counter #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [CW-1:0] r_count;

    // Settle count: cleared between vectors, advances once per settle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == CW'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 16 input combinations onto abcd, waits
// SETTLE_CYCLES per vector, then captures f_in into the truth table.
// Optional macro TT_SWEEP_COMPARE_EN adds a compare against an expected
// table (pass / first_mismatch), registered on entry to DONE.
// "table" is a reserved word, so the captured-table port is named tbl.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [IDX_W-1:0]       abcd,
    input  logic                   f_in,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_VECTORS-1:0] tbl
`ifdef TT_SWEEP_COMPARE_EN
    ,
    input  logic [NUM_VECTORS-1:0] expected,
    output logic                   pass,
    output logic [IDX_W-1:0]       first_mismatch
`endif
);

    tt_state_e              r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [NUM_VECTORS-1:0] r_table;
    logic                   w_expired;
    logic                   w_cnt_clear;
    logic                   w_cnt_en;
    logic                   w_last;

    assign w_cnt_clear = (r_state == ST_IDLE) || (r_state == ST_SAMPLE);
    assign w_cnt_en    = (r_state == ST_SETTLE);
    assign w_last      = (r_idx == IDX_W'(NUM_VECTORS - 1));

    settle_counter #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_cnt_clear),
        .enable  (w_cnt_en),
        .expired (w_expired)
    );

    // Sweep FSM: vector index, state sequencing and table capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_table <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SETTLE;
                        r_idx   <= '0;
                        r_table <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (w_expired) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    r_table[r_idx] <= f_in;
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign abcd = ((r_state == ST_SETTLE) || (r_state == ST_SAMPLE)) ? r_idx : '0;
    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);
    assign tbl  = r_table;

`ifdef TT_SWEEP_COMPARE_EN
    logic [NUM_VECTORS-1:0] w_final_table;
    logic                   r_pass;
    logic [IDX_W-1:0]       r_first_mismatch;

    // The last sample lands in r_table on the same edge that enters DONE,
    // so the compare uses the table with that final bit merged in.
    always_comb begin
        w_final_table        = r_table;
        w_final_table[r_idx] = f_in;
    end

    // Compare result: captured entering DONE, held until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass           <= 1'b0;
            r_first_mismatch <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_pass           <= 1'b0;
            r_first_mismatch <= '0;
        end else if ((r_state == ST_SAMPLE) && w_last) begin
            r_pass           <= (w_final_table == expected);
            r_first_mismatch <= first_diff(w_final_table, expected);
        end
    end

    assign pass           = r_pass;
    assign first_mismatch = r_first_mismatch;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: two instances (SETTLE_CYCLES=4
// and 1) driven by a selectable reference function of abcd.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start1;
    logic [3:0]  abcd, abcd1;
    logic        f_in, f_in1;
    logic        busy, busy1, done, done1;
    logic [15:0] tbl, tbl1;
    int          mode;      // 0: A&B, 1: XOR of all bits, 2: constant 1
    int unsigned checks = 0;
    int unsigned errors = 0;
`ifdef TT_SWEEP_COMPARE_EN
    logic [15:0] expected;
    logic        pass, pass1;
    logic [3:0]  fm, fm1;
`endif

    always #5 clk = ~clk;

    function automatic logic f_fn(input int m, input logic [3:0] v);
        case (m)
            0:       f_fn = v[3] & v[2];
            1:       f_fn = ^v;
            default: f_fn = 1'b1;
        endcase
    endfunction

    always_comb f_in  = f_fn(mode, abcd);
    always_comb f_in1 = 1'b1;

    truth_table_sweeper #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abcd(abcd), .f_in(f_in),
        .busy(busy), .done(done), .tbl(tbl)
`ifdef TT_SWEEP_COMPARE_EN
        , .expected(expected), .pass(pass), .first_mismatch(fm)
`endif
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abcd(abcd1), .f_in(f_in1),
        .busy(busy1), .done(done1), .tbl(tbl1)
`ifdef TT_SWEEP_COMPARE_EN
        , .expected(16'hFFFF), .pass(pass1), .first_mismatch(fm1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sweep on dut; n = cycle (accepting edge = cycle 1) where done is seen.
    task automatic sweep0(input int repulse_at, output int n);
        start = 1'b1;
        n = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            n++;
            if (n == 1) begin
                start = 1'b0;
                check("busy_after_accept", busy, 1);
            end
            if (n == repulse_at)     start = 1'b1;
            if (n == repulse_at + 1) start = 1'b0;
            if (n == 5) check("abcd_idx0_sample", abcd, 0);
            if (n == 6) check("abcd_idx1", abcd, 1);
            if (done) break;
        end
    endtask

    initial begin
        int n, first, second;
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0; mode = 0;
`ifdef TT_SWEEP_COMPARE_EN
        expected = 16'hF000;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_abcd", abcd, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tbl", tbl, 0);
        check("rst_tbl1", tbl1, 0);
`ifdef TT_SWEEP_COMPARE_EN
        check("rst_pass", pass, 0);
        check("rst_fm", fm, 0);
`endif
        rst_n = 1'b1;
        tick();

        // A&B sweep
        mode = 0;
        sweep0(0, n);
        check("and_done_cycle", n, 81);
        check("and_tbl", tbl, 16'hF000);
`ifdef TT_SWEEP_COMPARE_EN
        check("and_pass", pass, 1);
        check("and_fm", fm, 0);
`endif
        tick();
        check("and_busy_low", busy, 0);
        check("and_done_pulse", done, 0);
        repeat (3) tick();
        check("idle_hold_tbl", tbl, 16'hF000);
        check("idle_busy", busy, 0);

        // XOR sweep with start re-pulsed mid-sweep
        mode = 1;
`ifdef TT_SWEEP_COMPARE_EN
        expected = 16'h6996;
`endif
        sweep0(20, n);
        check("xor_done_cycle", n, 81);
        check("xor_tbl", tbl, 16'h6996);
`ifdef TT_SWEEP_COMPARE_EN
        check("xor_pass", pass, 1);
        check("xor_fm", fm, 0);
        tick();
        expected = 16'h6997;
        sweep0(0, n);
        check("xor6997_pass", pass, 0);
        check("xor6997_fm", fm, 0);
        tick();
        expected = 16'h6986;
        sweep0(0, n);
        check("xor6986_pass", pass, 0);
        check("xor6986_fm", fm, 4);
        repeat (3) tick();
        check("cmp_hold_fm", fm, 4);
        expected = 16'h6996;
`endif
        tick();

        // start held high: back-to-back sweeps
        start = 1'b1;
        n = 0; first = 0; second = 0;
        for (int k = 0; k < 400; k++) begin
            tick();
            n++;
            if (done) begin
                if (first == 0) first = n;
                else begin
                    second = n;
                    break;
                end
            end
        end
        start = 1'b0;
        check("b2b_first_done", first, 81);
        check("b2b_gap", second - first, 82);
        check("b2b_tbl", tbl, 16'h6996);
        repeat (2) tick();

        // reset in the middle of a sweep at idx 7
        mode = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (abcd == 4'd7) break;
            tick();
        end
        check("pre_rst_idx7", abcd, 7);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_abcd", abcd, 0);
        check("midrst_tbl", tbl, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        #2;
        rst_n = 1'b1;
        tick();
        mode = 1;
        sweep0(0, n);
        check("post_rst_done_cycle", n, 81);
        check("post_rst_tbl", tbl, 16'h6996);
        tick();

        // SETTLE_CYCLES = 1 instance, f_in tied high
        start1 = 1'b1;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            n++;
            if (n == 1) start1 = 1'b0;
            if (n == 2) check("s1_abcd_n2", abcd1, 0);
            if (n == 3) check("s1_abcd_n3", abcd1, 1);
            if (n == 5) check("s1_abcd_n5", abcd1, 2);
            if (done1) break;
        end
        check("s1_done_cycle", n, 33);
        check("s1_tbl", tbl1, 16'hFFFF);
        tick();
        check("s1_busy_low", busy1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: cycles abcd is held stable before f_in is sampled; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  sweep request; sampled only in IDLE.
REQ-005 SHALL have port abcd  output  4  stimulus to the 4-input function under test; A=abcd[3], B=abcd[2], C=abcd[1], D=abcd[0].
REQ-006 SHALL have port f_in  input  1  output of the function under test.
REQ-007 SHALL have port busy  output  1  high from the cycle after start is accepted until DONE, inclusive.
REQ-008 SHALL have port done  output  1  one-cycle pulse when the sweep completes.
REQ-009 SHALL have port table  output  16  captured truth table; bit i = f_in observed with abcd==i.

Function
REQ-010 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-011 IDLE with start=1 SHALL go to SETTLE and set idx=0, settle count=0, table=16'h0000.
REQ-012 IDLE with start=0 SHALL stay in IDLE and hold table unchanged.
REQ-013 SETTLE SHALL increment the settle count each cycle and go to SAMPLE when count==SETTLE_CYCLES-1.
REQ-014 SAMPLE SHALL write f_in into table[idx].
REQ-015 SAMPLE with idx<15 SHALL increment idx, clear the count and return to SETTLE.
REQ-016 SAMPLE with idx==15 SHALL go to DONE with no idx wrap.
REQ-017 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-018 abcd SHALL equal idx in SETTLE and SAMPLE, and 4'h0 in IDLE and DONE.
REQ-019 Each vector SHALL take SETTLE_CYCLES+1 cycles; done SHALL be high in cycle 16*(SETTLE_CYCLES+1)+1 after the edge that accepts start.
REQ-020 start while busy SHALL be ignored; no restart and no error.
REQ-021 start held high through DONE SHALL launch a new sweep on the IDLE cycle that follows.
REQ-022 table SHALL stay stable and readable from DONE until the next accepted start.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, idx=0, count=0, abcd=0, busy=0, done=0, table=16'h0000, including mid-sweep.
REQ-024 After rst_n deasserts, the block SHALL act on start no earlier than the first rising clk edge.

Configuration
REQ-025 Macro TT_SWEEP_COMPARE_EN, when defined, SHALL add: input expected[15:0], output pass (1), output first_mismatch (4).
REQ-026 With TT_SWEEP_COMPARE_EN, pass and first_mismatch SHALL be registered on entry to DONE and held until the next accepted start.
REQ-027 pass SHALL be 1 if and only if table==expected.
REQ-028 first_mismatch SHALL be the lowest index i with table[i]!=expected[i], and 0 when pass=1.
REQ-029 pass and first_mismatch SHALL reset to 0.
REQ-030 Without TT_SWEEP_COMPARE_EN, these ports and the compare logic SHALL be absent and all other behaviour identical.

Structure
REQ-031 Package tt_sweep_pkg SHALL hold the FSM state enum, NUM_VECTORS=16 and IDX_W=4.
REQ-032 The settle timer SHALL be sub-module settle_counter (inputs clear, enable; output expired), sized for SETTLE_CYCLES.

Verification
REQ-033 f_in=abcd[3]&abcd[2], SETTLE_CYCLES=4, pulse start -> done at cycle 81, table=16'hF000, busy low after DONE.
REQ-034 f_in=^abcd (XOR of all four bits) -> table=16'h6996; with macro and expected=16'h6996 -> pass=1, first_mismatch=0.
REQ-035 Macro on, f_in=^abcd, expected=16'h6997 -> pass=0, first_mismatch=0.
REQ-036 rst_n pulsed low at idx=7 mid-sweep -> abcd=0, table=0, busy=0 immediately; a new start gives a full 16-vector sweep.
REQ-037 start re-pulsed during a sweep -> ignored, done still at cycle 81; start held high continuously -> back-to-back sweeps with done every 82 cycles.
REQ-038 SETTLE_CYCLES=1, f_in=1 constant -> table=16'hFFFF, done at cycle 33, abcd steps every 2 cycles.
